// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// State encoding, port identifiers and watchdog defaults.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2,
        RESP  = 2'd3
    } state_e;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    localparam int TMO_DEFAULT = 64;
    localparam int WDOG_W      = 8;

endpackage

// File: rtl/mem_arb_wdog.sv
// Watchdog for the memory handshake: clearable, enabled up-counter.
// tc_o flags the enabled cycle on which the count reaches LIMIT.
module mem_arb_wdog
    import mem_arbiter_pkg::*;
#(
    parameter int W     = WDOG_W,
    parameter int LIMIT = TMO_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Clear wins over count; count only while enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter in front of a single-port memory.
// Alternating priority on contention, watchdog on the memory handshake.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int TMO = TMO_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ack,
    output logic [DW-1:0] i_rdata,
    output logic          i_err,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          d_err,
    output logic          m_req,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    input  logic          m_ready,
    output logic          busy
);

    state_e        state_q, state_d;
    logic          last_q, last_d;
    logic          m_req_q, m_req_d;
    logic          m_we_q, m_we_d;
    logic [AW-1:0] m_addr_q, m_addr_d;
    logic [DW-1:0] m_wdata_q, m_wdata_d;
    logic          i_ack_q, i_ack_d;
    logic [DW-1:0] i_rdata_q, i_rdata_d;
    logic          i_err_q, i_err_d;
    logic          d_ack_q, d_ack_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          d_err_q, d_err_d;

    logic          in_gnt;
    logic          wd_clr;
    logic          wd_en;
    logic          wd_tc;
    logic          rsp_done;
    logic          rsp_err;
    logic [DW-1:0] rsp_data;

    assign in_gnt = (state_q == GNT_I) || (state_q == GNT_D);
    assign wd_en  = in_gnt && !m_ready;

    mem_arb_wdog #(
        .W     (WDOG_W),
        .LIMIT (TMO)
    ) u_wdog (
        .clk   (clk),
        .reset (reset),
        .clr_i (wd_clr),
        .en_i  (wd_en),
        .tc_o  (wd_tc)
    );

    // Next state: grant, wait for memory or timeout, one-cycle ack.
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        m_req_d   = m_req_q;
        m_we_d    = m_we_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        i_ack_d   = 1'b0;
        i_rdata_d = i_rdata_q;
        i_err_d   = i_err_q;
        d_ack_d   = 1'b0;
        d_rdata_d = d_rdata_q;
        d_err_d   = d_err_q;
        wd_clr    = 1'b0;
        rsp_done  = 1'b0;
        rsp_err   = 1'b0;
        rsp_data  = '0;
        unique case (state_q)
            IDLE: begin
                if (i_req && (!d_req || last_q == PORT_D)) begin
                    state_d   = GNT_I;
                    last_d    = PORT_I;
                    m_req_d   = 1'b1;
                    m_we_d    = 1'b0;
                    m_addr_d  = i_addr;
                    m_wdata_d = '0;
                    wd_clr    = 1'b1;
                end else if (d_req) begin
                    state_d   = GNT_D;
                    last_d    = PORT_D;
                    m_req_d   = 1'b1;
                    m_we_d    = d_we;
                    m_addr_d  = d_addr;
                    m_wdata_d = d_wdata;
                    wd_clr    = 1'b1;
                end
            end
            GNT_I, GNT_D: begin
                if (m_ready) begin
                    rsp_done = 1'b1;
                    rsp_data = m_we_q ? '0 : m_rdata;
                end else if (wd_tc) begin
                    rsp_done = 1'b1;
                    rsp_err  = 1'b1;
                end
                if (rsp_done) begin
                    m_req_d = 1'b0;
                    state_d = RESP;
                    if (state_q == GNT_I) begin
                        i_ack_d   = 1'b1;
                        i_rdata_d = rsp_data;
                        i_err_d   = rsp_err;
                    end else begin
                        d_ack_d   = 1'b1;
                        d_rdata_d = rsp_data;
                        d_err_d   = rsp_err;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any memory op.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            last_q    <= PORT_I;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            i_ack_q   <= 1'b0;
            i_rdata_q <= '0;
            i_err_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            d_rdata_q <= '0;
            d_err_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            m_req_q   <= m_req_d;
            m_we_q    <= m_we_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            i_ack_q   <= i_ack_d;
            i_rdata_q <= i_rdata_d;
            i_err_q   <= i_err_d;
            d_ack_q   <= d_ack_d;
            d_rdata_q <= d_rdata_d;
            d_err_q   <= d_err_d;
        end
    end

    assign m_req   = m_req_q;
    assign m_we    = m_we_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign i_ack   = i_ack_q;
    assign i_rdata = i_rdata_q;
    assign i_err   = i_err_q;
    assign d_ack   = d_ack_q;
    assign d_rdata = d_rdata_q;
    assign d_err   = d_err_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic.
// Memory and arbitration order are modelled at transaction level.
module tb_mem_arbiter;

    localparam int TMO = 4;

    logic        clk;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        i_err;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_ready;
    logic        busy;

    int checks = 0;
    int errors = 0;

    // memory environment
    logic [31:0] mem [64];
    logic [31:0] ref_mem [64];
    logic        mem_init;
    logic        spurious;
    logic        rand_wait;
    int          fix_wait;
    int          cur_wait;
    int          wcnt;

    mem_arbiter #(.AW(32), .DW(32), .TMO(TMO)) dut (
        .clk     (clk),
        .reset   (reset),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_ack   (i_ack),
        .i_rdata (i_rdata),
        .i_err   (i_err),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_ack   (d_ack),
        .d_rdata (d_rdata),
        .d_err   (d_err),
        .m_req   (m_req),
        .m_we    (m_we),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_rdata (m_rdata),
        .m_ready (m_ready),
        .busy    (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] init_val(input int k);
        if (k == 16) return 32'h8C020004;
        return {16'hA5A5, k[7:0], 8'(k * 3)};
    endfunction

    assign m_ready = spurious || (m_req && (wcnt == cur_wait));
    assign m_rdata = mem[m_addr[7:2]];

    // memory: picks a wait per transaction, stores writes on ready
    always @(posedge clk) begin
        if (mem_init) begin
            for (int k = 0; k < 64; k++) mem[k] <= init_val(k);
        end
        if (!m_req) begin
            wcnt     <= 0;
            cur_wait <= rand_wait ? int'($urandom_range(0, 5)) : fix_wait;
        end else if (!m_ready) begin
            wcnt <= wcnt + 1;
        end
        if (m_req && m_ready && m_we) mem[m_addr[7:2]] <= m_wdata;
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // one transaction on a port; lat = cycles from sampling edge to ack
    task automatic do_txn(input logic port, input logic we,
                          input logic [31:0] addr,
                          input logic [31:0] wd, output int lat);
        @(negedge clk);
        if (port) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wd;
        end else begin
            i_req = 1'b1; i_addr = addr;
        end
        lat = -1;
        for (int c = 1; c <= 20 && lat < 0; c++) begin
            tick;
            if ((port ? d_ack : i_ack) === 1'b1) lat = c;
        end
        @(negedge clk);
        if (port) d_req = 1'b0;
        else i_req = 1'b0;
    endtask

    // simultaneous I/D requests; check grant order and read data
    task automatic run_pair(input logic exp_first, input string tag);
        logic [1:0] seq;
        int n;
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'h44;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h48;
        n = 0;
        seq = '0;
        for (int c = 0; c < 30 && n < 2; c++) begin
            tick;
            if (d_ack === 1'b1) begin
                seq[n[0]] = 1'b1;
                chk({tag, "_d_rdata"}, d_rdata, ref_mem[18]);
                n++;
                @(negedge clk);
                d_req = 1'b0;
            end else if (i_ack === 1'b1) begin
                seq[n[0]] = 1'b0;
                chk({tag, "_i_rdata"}, i_rdata, ref_mem[17]);
                n++;
                @(negedge clk);
                i_req = 1'b0;
            end
        end
        i_req = 1'b0;
        d_req = 1'b0;
        chk({tag, "_nacks"}, n, 2);
        chk({tag, "_first"}, seq[0], exp_first);
        chk({tag, "_second"}, seq[1], !exp_first);
    endtask

    int          lat;
    int          n;
    int          mcnt;
    int          idle_cnt;
    int          t[3];
    int          done;
    logic        got;
    logic        model_last;
    logic        p;
    logic        wep;
    logic        eexp;
    logic [31:0] ap;
    logic [31:0] wdp;
    logic [31:0] rexp;

    initial begin
        reset = 1'b1;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        mem_init = 1'b1; spurious = 1'b0;
        rand_wait = 1'b0; fix_wait = 0;
        for (int k = 0; k < 64; k++) ref_mem[k] = init_val(k);
        repeat (3) tick;
        mem_init = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        tick;

        // reset state
        chk("rst_busy", busy, 0);
        chk("rst_m_req", m_req, 0);
        chk("rst_m_addr", m_addr, 0);
        chk("rst_i_ack", i_ack, 0);
        chk("rst_d_ack", d_ack, 0);
        chk("rst_i_rdata", i_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        chk("rst_errs", {i_err, d_err}, 0);

        // m_ready while idle is ignored
        spurious = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick;
            chk("spur_busy", busy, 0);
            chk("spur_acks", {i_ack, d_ack}, 0);
        end
        spurious = 1'b0;

        // zero-wait fetch latency
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'h40;
        tick;
        chk("f_m_req", m_req, 1);
        chk("f_m_addr", m_addr, 32'h40);
        chk("f_m_we", m_we, 0);
        chk("f_busy", busy, 1);
        chk("f_no_ack", i_ack, 0);
        tick;
        chk("f_ack", i_ack, 1);
        chk("f_rdata", i_rdata, 32'h8C020004);
        chk("f_err", i_err, 0);
        chk("f_m_req_low", m_req, 0);
        @(negedge clk);
        i_req = 1'b0;
        tick;
        chk("f_ack_pulse", i_ack, 0);
        chk("f_idle", busy, 0);
        chk("f_rdata_hold", i_rdata, 32'h8C020004);

        // first contention after reset grants D
        run_pair(1'b1, "pair1");

        // write with three wait cycles
        fix_wait = 3;
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1;
        d_addr = 32'h100; d_wdata = 32'hDEADBEEF;
        for (int k = 0; k < 4; k++) begin
            tick;
            chk("w_m_req", m_req, 1);
            chk("w_m_we", m_we, 1);
            chk("w_m_addr", m_addr, 32'h100);
            chk("w_m_wdata", m_wdata, 32'hDEADBEEF);
            chk("w_no_ack", d_ack, 0);
        end
        tick;
        chk("w_ack", d_ack, 1);
        chk("w_rdata", d_rdata, 0);
        chk("w_err", d_err, 0);
        chk("w_m_req_low", m_req, 0);
        ref_mem[0] = 32'hDEADBEEF;
        @(negedge clk);
        d_req = 1'b0; d_we = 1'b0;

        // last grant was D, so contention now favours I
        fix_wait = 0;
        run_pair(1'b0, "pair2");

        // watchdog timeout on the data port
        fix_wait = 1000;
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
        mcnt = 0;
        got = 1'b0;
        for (int c = 0; c < 12 && !got; c++) begin
            tick;
            if (m_req) mcnt++;
            if (d_ack === 1'b1) begin
                got = 1'b1;
                chk("to_err", d_err, 1);
                chk("to_rdata", d_rdata, 0);
            end
        end
        chk("to_got_ack", got, 1);
        chk("to_m_req_cycles", mcnt, TMO);
        @(negedge clk);
        d_req = 1'b0;
        fix_wait = 1;
        do_txn(1'b1, 1'b0, 32'h40, 32'h0, lat);
        chk("post_to_lat", lat, 3);
        chk("post_to_err", d_err, 0);
        chk("post_to_rdata", d_rdata, 32'h8C020004);

        // reset during a pending fetch
        fix_wait = 1000;
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'h80;
        tick;
        chk("rm_m_req", m_req, 1);
        tick;
        #2;
        reset = 1'b1;
        #1;
        chk("rm_m_req_low", m_req, 0);
        chk("rm_busy", busy, 0);
        chk("rm_no_ack", i_ack, 0);
        chk("rm_data_clr", {i_rdata, d_rdata}, 0);
        i_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        fix_wait = 0;
        for (int k = 0; k < 3; k++) begin
            tick;
            chk("rm_after_ack", i_ack, 0);
            chk("rm_after_busy", busy, 0);
        end

        // held fetch request: three back-to-back transactions
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'h40;
        n = 0;
        idle_cnt = 0;
        for (int c = 1; c <= 30 && n < 3; c++) begin
            tick;
            if (n >= 1 && !busy) idle_cnt++;
            if (i_ack === 1'b1) begin
                t[n] = c;
                chk("b2b_rdata", i_rdata, 32'h8C020004);
                n++;
                if (n == 3) begin
                    @(negedge clk);
                    i_req = 1'b0;
                end
            end
        end
        i_req = 1'b0;
        chk("b2b_count", n, 3);
        chk("b2b_first", t[0], 2);
        chk("b2b_gap1", t[1] - t[0], 3);
        chk("b2b_gap2", t[2] - t[1], 3);
        chk("b2b_idle", idle_cnt, 2);

        // random traffic, both ports always requesting
        rand_wait = 1'b1;
        model_last = 1'b0;
        tick;
        i_addr = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
        d_we = 1'($urandom_range(0, 1));
        d_addr = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
        d_wdata = $urandom;
        i_req = 1'b1;
        d_req = 1'b1;
        done = 0;
        for (int c = 0; c < 4000 && done < 60; c++) begin
            tick;
            if (i_ack === 1'b1 || d_ack === 1'b1) begin
                p = d_ack;
                chk("rnd_one_ack", {i_ack, d_ack} == 2'b11, 0);
                chk("rnd_order", p, !model_last);
                ap  = p ? d_addr : i_addr;
                wep = p ? d_we : 1'b0;
                wdp = d_wdata;
                eexp = (cur_wait >= TMO);
                rexp = (eexp || wep) ? 32'h0 : ref_mem[ap[7:2]];
                if (wep && !eexp) ref_mem[ap[7:2]] = wdp;
                if (p) begin
                    chk("rnd_d_rdata", d_rdata, rexp);
                    chk("rnd_d_err", d_err, eexp);
                    d_we = 1'($urandom_range(0, 1));
                    d_addr = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
                    d_wdata = $urandom;
                end else begin
                    chk("rnd_i_rdata", i_rdata, rexp);
                    chk("rnd_i_err", i_err, eexp);
                    i_addr = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
                end
                model_last = p;
                done++;
            end
        end
        chk("rnd_done", done, 60);
        i_req = 1'b0;
        d_req = 1'b0;
        repeat (8) tick;
        chk("end_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
